vga_canvas_arbiter: RTL and testbench
=====================================

Name: vga_canvas_arbiter

Overview:
- Shares one single-port handwriting canvas RAM (320x240, 76800 words, 2x upscaled to 640x480) between three requesters: the VGA scan-out read, a pixel-write requester (stroke drawing) and a full-canvas clear engine.
- Scan-out owns the RAM on every active-video cycle.
- Writes are buffered in a small FIFO and drained only during blanking.
- Sits between the VGA timing controller / pixel mux and the canvas block memory; runs on the 25 MHz pixel clock.

Parameters:
- DW, 1, canvas pixel data width.
- FIFO_DEPTH, 8, pending-write FIFO entries (power of 2, >=2).
- CANVAS_WORDS, 76800, canvas size; also the clear sweep length.

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- valid  in  1  active-video flag from VGA timing controller
- h_cnt  in  10  horizontal pixel count (0..639 when valid)
- v_cnt  in  10  vertical pixel count (0..479 when valid)
- wr_req  in  1  write request
- wr_addr  in  17  canvas write address
- wr_data  in  DW  canvas write data
- wr_ready  out  1  FIFO can accept a write this cycle
- clr_req  in  1  clear-canvas request (level or pulse)
- clr_busy  out  1  clear sweep in progress
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  17  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM read data, 1-cycle latency
- pix_data  out  DW  canvas pixel to the pixel mux
- pix_valid  out  1  pix_data corresponds to an active-video pixel

Behaviour:
- Reset (rst=0, async): FIFO empty; state IDLE; clr_busy=0; wr_ready=0; mem_en=0; mem_we=0; mem_addr=0; mem_din=0; pix_data=0; pix_valid=0. wr_ready rises on the first clock after release.
- Scan address: scan_addr = (h_cnt>>1) + 320*(v_cnt>>1), built as (v>>1)<<8 + (v>>1)<<6 + (h>>1). No modulo.
- RAM port outputs are registered. The slot is decided from the current-cycle inputs and appears on the RAM pins the next cycle.
- Slot priority per cycle:
  1. valid=1: read scan_addr, we=0.
  2. else CLEAR: write 0 to clr_cnt.
  3. else FIFO non-empty: pop the head and write it.
  4. else mem_en=0.
- Scan latency: valid/h/v in cycle N -> mem_addr in N+1 -> mem_dout in N+2 -> pix_data/pix_valid registered in N+3. pix_valid is valid delayed by 3 cycles. When pix_valid=0, pix_data=0.
- FIFO:
  - Push when wr_req && wr_ready.
  - wr_ready = !full && state!=CLEAR, derived from registered count.
  - A pop in the same cycle does not raise wr_ready that cycle.
  - Simultaneous push and pop keeps count unchanged and preserves order.
  - A write with wr_ready=0 is not accepted; the requester holds wr_req.
- States:
  - IDLE: clr_req=1 -> CLEAR. On entry clr_cnt=0, FIFO flushed, clr_busy=1 the next cycle.
  - CLEAR: clr_cnt increments only on non-valid cycles. After the write slot for CANVAS_WORDS-1 is issued, go to IDLE; clr_busy=0 the following cycle.
  - clr_req while in CLEAR is ignored. clr_req held high re-triggers after completion.
- Writes never occur on a valid=1 cycle; a clear or drain interrupted by valid resumes at the same address/entry.
- Reset mid-clear or with a non-empty FIFO abandons all state; no partial-state recovery.

Optional Feature:
- Macro WR_ADDR_CHECK_EN.
- Defined: adds output wr_err (1 bit, reset 0). A request with wr_addr >= CANVAS_WORDS is accepted (handshake completes) but discarded, not pushed. wr_err sets sticky and clears only on a clr_req that starts a clear, or on reset.
- Undefined: no wr_err port; every accepted write is pushed, and out-of-range addresses reach the RAM unchanged.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release -> wr_ready=1 after 1 clk, mem_en=0 while idle in blanking.
- Scan: valid=1, h=5, v=3 -> next cycle mem_addr=322, mem_we=0. RAM model returns 1 -> pix_data=1, pix_valid=1 exactly 3 cycles after input.
- Buffered write: push {addr 100, data 1} during valid=1 -> no mem_we while valid. First blanking cycle -> next cycle mem_we=1, mem_addr=100, mem_din=1.
- FIFO full: push 9 writes during active video -> 8 accepted, wr_ready=0 from the cycle after the 8th push. In blanking, drained in order with one write per cycle.
- Clear: 3 entries pending, pulse clr_req in blanking -> FIFO flushed, clr_busy=1, addresses 0..76799 written with 0 skipping all valid cycles. clr_busy falls 1 cycle after the last write. A second clr_req mid-sweep has no effect.
- Reset mid-clear at clr_cnt=5000 -> clr_busy=0 immediately. After release no further clear writes occur.

Source files
------------

// File: rtl/vga_canvas_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_canvas_arbiter_if
// Bundles every signal of the canvas arbiter except clock and reset.
//   VGA timing : valid, h_cnt[9:0], v_cnt[9:0]
//   Write port : wr_req, wr_addr[16:0], wr_data[DW-1:0], wr_ready
//   Clear      : clr_req, clr_busy
//   Canvas RAM : mem_en, mem_we, mem_addr[16:0], mem_din[DW-1:0], mem_dout[DW-1:0]
//   Pixel out  : pix_data[DW-1:0], pix_valid
//   wr_err     : only present when WR_ADDR_CHECK_EN is defined
// Modports: slave = the arbiter itself, master = its surroundings
// (timing controller, stroke writer, clear requester, RAM).
// -----------------------------------------------------------------------------
interface vga_canvas_arbiter_if #(
   parameter int DW = 1
);
   logic          valid;
   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic          wr_req;
   logic [16:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          clr_req;
   logic          clr_busy;
   logic          mem_en;
   logic          mem_we;
   logic [16:0]   mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
`ifdef WR_ADDR_CHECK_EN
   logic          wr_err;
`endif

   modport slave (
      input  valid, h_cnt, v_cnt, wr_req, wr_addr, wr_data, clr_req, mem_dout,
`ifdef WR_ADDR_CHECK_EN
      output wr_err,
`endif
      output wr_ready, clr_busy, mem_en, mem_we, mem_addr, mem_din,
             pix_data, pix_valid
   );

   modport master (
      output valid, h_cnt, v_cnt, wr_req, wr_addr, wr_data, clr_req, mem_dout,
`ifdef WR_ADDR_CHECK_EN
      input  wr_err,
`endif
      input  wr_ready, clr_busy, mem_en, mem_we, mem_addr, mem_din,
             pix_data, pix_valid
   );
endinterface

// File: rtl/vga_canvas_arbiter.sv
// -----------------------------------------------------------------------------
// vga_canvas_arbiter
// Shares one single-port 320x240 canvas RAM between VGA scan-out (owns every
// active-video cycle), a buffered pixel-write requester (drained in blanking)
// and a full-canvas clear engine. Runs on the 25 MHz pixel clock.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous, active-low reset
//   bus  - vga_canvas_arbiter_if.slave (timing, write port, clear, RAM, pixel)
// Optional feature macro: WR_ADDR_CHECK_EN
//   defined   -> out-of-range writes are accepted but dropped, sticky wr_err
//   undefined -> every accepted write is queued unchanged, no wr_err
// Slot priority per cycle: scan read > clear write > FIFO drain > idle.
// -----------------------------------------------------------------------------
module vga_canvas_arbiter #(
   parameter int DW           = 1,
   parameter int FIFO_DEPTH   = 8,
   parameter int CANVAS_WORDS = 76800
) (
   input  logic                clk,
   input  logic                rst,
   vga_canvas_arbiter_if.slave bus
);
   localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              CW        = PW + 1;
   localparam logic [16:0]     CLR_LAST  = 17'(CANVAS_WORDS - 1);
   localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [16:0]   clr_cnt_r;
   logic          clr_busy_r;
   logic          wr_ready_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [16:0]   fifo_addr_r [FIFO_DEPTH];
   logic [DW-1:0] fifo_data_r [FIFO_DEPTH];

   logic          mem_en_r;
   logic          mem_we_r;
   logic [16:0]   mem_addr_r;
   logic [DW-1:0] mem_din_r;
   logic          valid_d1_r;
   logic          valid_d2_r;
   logic [DW-1:0] pix_data_r;
   logic          pix_valid_r;

   logic [16:0]   v_half_s;
   logic [16:0]   h_half_s;
   logic [16:0]   scan_addr_s;
   logic          clr_start_s;
   logic          clr_wr_s;
   logic          clr_last_s;
   logic          push_req_s;
   logic          push_s;
   logic          pop_s;
`ifdef WR_ADDR_CHECK_EN
   logic          addr_bad_s;
   logic          wr_err_r;
`endif

   // Slot decision, FIFO handshake and next-state computation from current inputs
   always_comb begin
      v_half_s    = {8'd0, bus.v_cnt[9:1]};
      h_half_s    = {8'd0, bus.h_cnt[9:1]};
      // 320*y = (y<<8) + (y<<6); any overflow simply wraps in 17 bits
      scan_addr_s = (v_half_s << 8) + (v_half_s << 6) + h_half_s;

      clr_start_s = (state_r == ST_IDLE) && bus.clr_req;
      clr_wr_s    = (state_r == ST_CLEAR) && !bus.valid;
      clr_last_s  = (clr_cnt_r == CLR_LAST);
      push_req_s  = bus.wr_req && wr_ready_r;
`ifdef WR_ADDR_CHECK_EN
      addr_bad_s  = ({15'd0, bus.wr_addr} >= 32'(CANVAS_WORDS));
      push_s      = push_req_s && !addr_bad_s;
`else
      push_s      = push_req_s;
`endif
      // A clear start flushes the FIFO, so nothing is drained in that cycle
      pop_s       = !bus.valid && (state_r == ST_IDLE) && !clr_start_s &&
                    (count_r != {CW{1'b0}});

      if (clr_start_s) begin
         count_nxt_s = {CW{1'b0}};
      end else begin
         count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      end

      state_nxt_s = state_r;
      if (clr_start_s) begin
         state_nxt_s = ST_CLEAR;
      end else if (clr_wr_s && clr_last_s) begin
         state_nxt_s = ST_IDLE;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Control state, FIFO bookkeeping, registered RAM slot and pixel pipeline
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         clr_cnt_r   <= 17'd0;
         clr_busy_r  <= 1'b0;
         wr_ready_r  <= 1'b0;
         count_r     <= {CW{1'b0}};
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 17'd0;
         mem_din_r   <= {DW{1'b0}};
         valid_d1_r  <= 1'b0;
         valid_d2_r  <= 1'b0;
         pix_data_r  <= {DW{1'b0}};
         pix_valid_r <= 1'b0;
`ifdef WR_ADDR_CHECK_EN
         wr_err_r    <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt_s;
         count_r    <= count_nxt_s;
         clr_busy_r <= (state_nxt_s == ST_CLEAR);
         // Registered from next count/state: a same-cycle pop cannot raise it early
         wr_ready_r <= (count_nxt_s != FIFO_FULL) && (state_nxt_s != ST_CLEAR);

         if (clr_start_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PW'(1);
            end
         end

         // The sweep counter only advances on cycles where a clear write is issued
         if (clr_start_s) begin
            clr_cnt_r <= 17'd0;
         end else if (clr_wr_s && !clr_last_s) begin
            clr_cnt_r <= clr_cnt_r + 17'd1;
         end

         if (bus.valid) begin
            mem_en_r   <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= scan_addr_s;
            mem_din_r  <= {DW{1'b0}};
         end else if (clr_wr_s) begin
            mem_en_r   <= 1'b1;
            mem_we_r   <= 1'b1;
            mem_addr_r <= clr_cnt_r;
            mem_din_r  <= {DW{1'b0}};
         end else if (pop_s) begin
            mem_en_r   <= 1'b1;
            mem_we_r   <= 1'b1;
            mem_addr_r <= fifo_addr_r[rd_ptr_r];
            mem_din_r  <= fifo_data_r[rd_ptr_r];
         end else begin
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 17'd0;
            mem_din_r  <= {DW{1'b0}};
         end

         // valid -> address on pins -> RAM data -> pixel register
         valid_d1_r  <= bus.valid;
         valid_d2_r  <= valid_d1_r;
         pix_valid_r <= valid_d2_r;
         pix_data_r  <= valid_d2_r ? bus.mem_dout : {DW{1'b0}};

`ifdef WR_ADDR_CHECK_EN
         if (clr_start_s) begin
            wr_err_r <= 1'b0;
         end else if (push_req_s && addr_bad_s) begin
            wr_err_r <= 1'b1;
         end
`endif
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
         fifo_data_r[wr_ptr_r] <= bus.wr_data;
      end
   end

   assign bus.wr_ready  = wr_ready_r;
   assign bus.clr_busy  = clr_busy_r;
   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_din   = mem_din_r;
   assign bus.pix_data  = pix_data_r;
   assign bus.pix_valid = pix_valid_r;
`ifdef WR_ADDR_CHECK_EN
   assign bus.wr_err    = wr_err_r;
`endif

endmodule

// File: tb/tb_vga_canvas_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_canvas_arbiter
// Self-checking bench for vga_canvas_arbiter: a table of single-cycle vectors
// followed by hand-written sequences for reset, pixel latency, FIFO full,
// the full clear sweep and reset during a clear.
// -----------------------------------------------------------------------------
module tb_vga_canvas_arbiter;
   localparam int DW    = 1;
   localparam int WORDS = 76800;

   logic clk;
   logic rst;

   vga_canvas_arbiter_if #(.DW(DW)) bus ();

   vga_canvas_arbiter #(
      .DW(DW),
      .FIFO_DEPTH(8),
      .CANVAS_WORDS(WORDS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec;
   int n_err;

   typedef struct {
      logic          valid;
      logic [9:0]    h;
      logic [9:0]    v;
      logic          wr_req;
      logic [16:0]   wr_addr;
      logic [DW-1:0] wr_data;
      logic          clr_req;
      logic          e_en;
      logic          e_we;
      logic [16:0]   e_addr;
      logic [DW-1:0] e_din;
      logic          e_rdy;
      logic          e_busy;
   } vec_t;

   vec_t vecs [12];

   // 25 MHz pixel clock (period 10 time units)
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Canvas RAM model: 1-cycle registered read; only word 322 holds a 1
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_dout <= '0;
      end else if (bus.mem_en && !bus.mem_we) begin
         bus.mem_dout <= (bus.mem_addr == 17'd322) ? 1'b1 : 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vl, input logic [9:0] h, input logic [9:0] v,
                        input logic wq, input logic [16:0] wa, input logic [DW-1:0] wd,
                        input logic cq);
      bus.valid   = vl;
      bus.h_cnt   = h;
      bus.v_cnt   = v;
      bus.wr_req  = wq;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.clr_req = cq;
   endtask

   // Watchdog: the run is bounded even if the DUT never finishes a sweep
   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          exp_addr;
      int          bad;
      int          iter;
      int          writes;
      logic        vl;
      logic [16:0] a_act;
      logic [DW-1:0] d_act;

      n_vec = 0;
      n_err = 0;

      //           valid h     v     req addr     data clr | en  we  addr     din  rdy busy
      vecs[0]  = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 10'd5,   10'd3,   1'b0, 17'd0,   1'b0, 1'b0, 1'b1, 1'b0, 17'd322,   1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 10'd639, 10'd479, 1'b1, 17'd100, 1'b1, 1'b0, 1'b1, 1'b0, 17'd76799, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b1, 1'b1, 17'd100,   1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 10'd0,   10'd0,   1'b1, 17'd200, 1'b1, 1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b1, 1'b1, 17'd200,   1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 10'd1,   10'd1,   1'b1, 17'd300, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 10'd0,   10'd0,   1'b1, 17'd301, 1'b1, 1'b0, 1'b1, 1'b1, 17'd300,   1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b1, 1'b1, 17'd301,   1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0,   1'b0, 1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b0};

      // ---------------- reset with random inputs ----------------
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'($urandom), 10'($urandom), 10'($urandom), 1'($urandom),
               17'($urandom), DW'($urandom), 1'($urandom));
         step();
         chk($sformatf("reset_out%0d", i),
             {8'd0, bus.wr_ready, bus.clr_busy, bus.mem_en, bus.mem_we,
              bus.mem_addr, bus.mem_din, bus.pix_data, bus.pix_valid}, 32'd0);
      end
      drive(1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      step();
      chk("release_ready", {30'd0, bus.wr_ready, bus.mem_en}, 32'h2);

      // ---------------- table-driven single-cycle vectors ----------------
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].valid, vecs[i].h, vecs[i].v, vecs[i].wr_req,
               vecs[i].wr_addr, vecs[i].wr_data, vecs[i].clr_req);
         step();
         a_act = vecs[i].e_en ? bus.mem_addr : 17'd0;
         d_act = vecs[i].e_we ? bus.mem_din : '0;
         chk($sformatf("vec%0d", i),
             {10'd0, bus.mem_en, bus.mem_we, a_act, d_act, bus.wr_ready, bus.clr_busy},
             {10'd0, vecs[i].e_en, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_din,
              vecs[i].e_rdy, vecs[i].e_busy});
      end

      // ---------------- scan latency: pixel 3 cycles after input ----------------
      drive(1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 1'b0, 1'b0);
      step(); step(); step();
      drive(1'b1, 10'd5, 10'd3, 1'b0, 17'd0, 1'b0, 1'b0);   // addr 322 -> 1
      step();
      chk("pix_e1", {30'd0, bus.pix_valid, bus.pix_data}, 32'd0);
      drive(1'b1, 10'd7, 10'd3, 1'b0, 17'd0, 1'b0, 1'b0);   // addr 323 -> 0
      step();
      chk("pix_e2", {30'd0, bus.pix_valid, bus.pix_data}, 32'd0);
      drive(1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 1'b0, 1'b0);
      step();
      chk("pix_e3", {30'd0, bus.pix_valid, bus.pix_data}, 32'h3);
      step();
      chk("pix_e4", {30'd0, bus.pix_valid, bus.pix_data}, 32'h2);
      step();
      chk("pix_e5", {30'd0, bus.pix_valid, bus.pix_data}, 32'd0);

      // ---------------- FIFO full during active video ----------------
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 10'd0, 10'd0, 1'b1, 17'(1000 + i), DW'(i % 2), 1'b0);
         step();
         chk($sformatf("fill_rdy%0d", i), {31'd0, bus.wr_ready}, {31'd0, (i != 7)});
         chk($sformatf("fill_nowe%0d", i), {31'd0, bus.mem_we}, 32'd0);
      end
      drive(1'b1, 10'd0, 10'd0, 1'b1, 17'd1008, 1'b1, 1'b0);
      step();
      chk("ninth_rejected", {31'd0, bus.wr_ready}, 32'd0);
      drive(1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("drain%0d", i),
             {12'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din},
             {12'd0, 1'b1, 1'b1, 17'(1000 + i), DW'(i % 2)});
         if (i == 0) begin
            chk("drain_rdy", {31'd0, bus.wr_ready}, 32'd1);
         end
      end
      step();
      chk("drain_done", {31'd0, bus.mem_en}, 32'd0);

      // ---------------- full clear sweep with 3 pending writes ----------------
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 10'd0, 10'd0, 1'b1, 17'(2000 + i), 1'b1, 1'b0);
         step();
      end
      drive(1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 1'b0, 1'b1);
      step();
      chk("clr_start", {29'd0, bus.mem_en, bus.clr_busy, bus.wr_ready}, 32'h2);
      bus.clr_req = 1'b0;
      exp_addr = 0;
      bad      = 0;
      iter     = 0;
      while (exp_addr < WORDS && iter < 80000) begin
         vl = (iter < 2000) && (iter % 4 == 0);
         bus.valid   = vl;
         bus.clr_req = (iter == 1000);   // must be ignored mid-sweep
         step();
         if (vl) begin
            if (!(bus.mem_en && !bus.mem_we)) bad = bad + 1;
            if (bus.clr_busy !== 1'b1) bad = bad + 1;
         end else begin
            if (!(bus.mem_en && bus.mem_we && bus.mem_addr == 17'(exp_addr) &&
                  bus.mem_din == '0)) bad = bad + 1;
            exp_addr = exp_addr + 1;
            if (bus.clr_busy !== (exp_addr != WORDS)) bad = bad + 1;
         end
         iter = iter + 1;
      end
      chk("clr_sweep_len", 32'(exp_addr), 32'(WORDS));
      chk("clr_sweep_errs", 32'(bad), 32'd0);
      drive(1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 1'b0, 1'b0);
      step();
      chk("clr_after", {29'd0, bus.mem_en, bus.clr_busy, bus.wr_ready}, 32'h1);

      // ---------------- reset in the middle of a clear ----------------
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      exp_addr = 0;
      bad      = 0;
      iter     = 0;
      while (exp_addr < 5000 && iter < 6000) begin
         step();
         if (bus.mem_we && bus.mem_addr == 17'(exp_addr)) exp_addr = exp_addr + 1;
         else bad = bad + 1;
         iter = iter + 1;
      end
      chk("mid_clr_reach", 32'(exp_addr), 32'd5000);
      chk("mid_clr_errs", 32'(bad), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_clr", {28'd0, bus.clr_busy, bus.mem_en, bus.mem_we, bus.wr_ready}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      writes = 0;
      bad    = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.mem_we) writes = writes + 1;
         if (bus.clr_busy) bad = bad + 1;
      end
      chk("post_rst_writes", 32'(writes), 32'd0);
      chk("post_rst_busy", 32'(bad), 32'd0);
      chk("post_rst_ready", {31'd0, bus.wr_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
